context_switch_scheduler: RTL
=============================

# context_switch_scheduler

Sequences context switches for the per-edge context memories in the decoding array. It owns `global_stage` during save and restore, and selects which pending context the decode controller runs next. It drives `local_context_switch` so every edge link's memory address pointer stays aligned with `active_context`. It sits between the top-level decode controller and the broadcast stage bus feeding all links and PEs.

## Interface
Parameters:
- `NUM_CONTEXTS`, 2: number of stored contexts; must match the links' memory depth.
- `RESTORE_GAP`, 1: idle cycles between the SAVE and RESTORE stages. Covers the link's stage register plus the single-port RAM read latency.
- `CTX_WIDTH`, `max(1,$clog2(NUM_CONTEXTS))`: width of the context index.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `context_req` in NUM_CONTEXTS: level request per context. Held high until the matching `context_ack`.
- `stage_in` in STAGE_WIDTH: stage requested by the decode controller while in RUN.
- `decode_done` in 1: 1-cycle pulse; the decode controller has finished or paused the active context.
- `global_stage` out STAGE_WIDTH: broadcast stage bus, registered.
- `local_context_switch` out 1: to all edge links, registered.
- `active_context` out CTX_WIDTH: context currently loaded in the array.
- `run_start` out 1: 1-cycle pulse; the decode controller may begin on `active_context`.
- `context_ack` out NUM_CONTEXTS: one-hot 1-cycle pulse, coincident with `run_start`.
- `busy` out 1: high in SAVE, GAP and RESTORE.

## Operation
- States:
  - IDLE: array loaded with `active_context`, no work.
  - RUN: decode controller owns the stage bus.
  - SAVE: 1 cycle.
  - GAP: `RESTORE_GAP` cycles.
  - RESTORE: 1 cycle.
  - START: 1 cycle.
- Link memory pointers advance by exactly one per non-local write, in order. Contexts are therefore visited strictly in sequence `c -> c+1 mod NUM_CONTEXTS`; skipping a context is never allowed.
- Selection in IDLE, or on `decode_done` in RUN, with c = `active_context` and n = c+1 mod N:
  - `context_req[c]`=1 → START; no save is needed because the state is already resident. This is checked first, so a context that keeps requesting always keeps the array.
  - Else if any `context_req` bit is set → SAVE (remote switch toward n).
  - Else → IDLE.
- Entering RESTORE sets `active_context` to n.
- After RESTORE:
  - If `context_req[n]`=1 → START.
  - Else if another request is pending → SAVE again to step onward.
  - Else → IDLE.
- START: pulse `run_start` and `context_ack[active_context]`, then go to RUN.
- `global_stage` by state:
  - SAVE: STAGE_WRITE_TO_MEM.
  - GAP: STAGE_IDLE.
  - RESTORE: STAGE_READ_FROM_MEM.
  - IDLE and START: STAGE_IDLE.
  - RUN: `stage_in`, except that STAGE_WRITE_TO_MEM and STAGE_READ_FROM_MEM from `stage_in` are replaced by STAGE_IDLE. Only this block issues them.
- `local_context_switch`:
  - Default 1, so a write is local (no pointer advance, bypass on read).
  - Driven 0 only in the cycle after each SAVE cycle, because links compare their registered stage against the unregistered `local_context_switch`.
  - NUM_CONTEXTS=1: never 0, and SAVE is never entered because n=c.
- `decode_done` outside RUN is ignored. Request changes during SAVE, GAP or RESTORE affect only the post-RESTORE decision.

## Timing
- Reset values:
  - state IDLE
  - `global_stage` STAGE_IDLE
  - `local_context_switch` 1
  - `active_context` 0
  - `run_start` 0
  - `context_ack` 0
  - `busy` 0
- After reset, the link pointers are 0, consistent with `active_context`=0.
- All outputs are registered. A state decision made in cycle t appears on the outputs at t+1.
- Remote switch with the next context requesting, `decode_done` at t:
  - SAVE output at t+1.
  - GAP at t+2 .. t+1+RESTORE_GAP.
  - RESTORE at t+2+RESTORE_GAP.
  - `run_start` at t+3+RESTORE_GAP.
- Same-context rerun: `decode_done` at t → `run_start` at t+1.
- From IDLE, a request seen at t → START output at t+1, or SAVE at t+1.
- Reset mid-switch: returns to reset values next cycle and abandons the switch. The links reset their pointers under the same reset, so alignment is preserved; contents of the context memory are undefined.

## Test plan
- Reset then `context_req`=01 (N=2) → `run_start` and `context_ack`=01 on the 2nd cycle after the request. `active_context`=0, no WRITE_TO_MEM ever issued.
- In RUN on context 0 with req=10, pulse `decode_done` → WRITE_TO_MEM, IDLE, READ_FROM_MEM on consecutive cycles. `local_context_switch`=0 only in the IDLE cycle, `active_context`=1, `context_ack`=10 one cycle after READ.
- N=4, active 0, only req[2] set → two back-to-back remote switches (0→1→2). Exactly two cycles with `local_context_switch`=0, no ack for context 1, `run_start` with `active_context`=2.
- `stage_in`=STAGE_WRITE_TO_MEM during RUN → `global_stage`=STAGE_IDLE; `local_context_switch` stays 1.
- Reset asserted in GAP → next cycle `global_stage`=STAGE_IDLE, `active_context`=0, `busy`=0, `local_context_switch`=1.
- With req[c] and req[n] both set at `decode_done` → START with no save; context c retains the array, and `context_ack` is one-hot on c.

Source files
------------

// File: rtl/context_switch_scheduler.sv
// Sequences save/gap/restore context switches on the broadcast stage bus and
// picks which pending context runs next, strictly in ring order.
module context_switch_scheduler #(
  parameter int unsigned NUM_CONTEXTS = 2,
  parameter int unsigned RESTORE_GAP  = 1,
  parameter int unsigned CTX_WIDTH    = (NUM_CONTEXTS > 1) ? $clog2(NUM_CONTEXTS) : 1,
  parameter int unsigned STAGE_WIDTH  = 3,
  parameter logic [STAGE_WIDTH-1:0] STAGE_IDLE          = STAGE_WIDTH'(0),
  parameter logic [STAGE_WIDTH-1:0] STAGE_READ_FROM_MEM = STAGE_WIDTH'(1),
  parameter logic [STAGE_WIDTH-1:0] STAGE_WRITE_TO_MEM  = STAGE_WIDTH'(2)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CONTEXTS-1:0] context_req,
  input  logic [STAGE_WIDTH-1:0]  stage_in,
  input  logic                    decode_done,
  output logic [STAGE_WIDTH-1:0]  global_stage,
  output logic                    local_context_switch,
  output logic [CTX_WIDTH-1:0]    active_context,
  output logic                    run_start,
  output logic [NUM_CONTEXTS-1:0] context_ack,
  output logic                    busy
);

  localparam int unsigned GAP_W    = (RESTORE_GAP > 1) ? $clog2(RESTORE_GAP) : 1;
  localparam int unsigned GAP_LAST = (RESTORE_GAP > 0) ? RESTORE_GAP - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RUN, ST_SAVE, ST_GAP, ST_RESTORE, ST_START
  } state_t;

  state_t                  state, next_state;
  logic [GAP_W-1:0]        gap_cnt, next_gap;
  logic [CTX_WIDTH-1:0]    next_active, succ_ctx;
  logic [STAGE_WIDTH-1:0]  stage_d, run_stage;
  logic                    run_start_d, busy_d;
  logic [NUM_CONTEXTS-1:0] ack_d;

  assign succ_ctx = (active_context == CTX_WIDTH'(NUM_CONTEXTS - 1)) ?
                    '0 : active_context + CTX_WIDTH'(1);

  // Save/restore codes are reserved for this block; mask them off the controller.
  assign run_stage = ((stage_in == STAGE_WRITE_TO_MEM) || (stage_in == STAGE_READ_FROM_MEM)) ?
                     STAGE_IDLE : stage_in;

  always_comb begin
    next_state  = state;
    next_gap    = gap_cnt;
    next_active = active_context;
    case (state)
      ST_IDLE: begin
        if (context_req[active_context]) next_state = ST_START;
        else if (|context_req)           next_state = ST_SAVE;
      end
      ST_RUN: begin
        if (decode_done) begin
          if (context_req[active_context]) next_state = ST_START;
          else if (|context_req)           next_state = ST_SAVE;
          else                             next_state = ST_IDLE;
        end
      end
      ST_SAVE: begin
        next_gap = '0;
        if (RESTORE_GAP == 0) begin
          next_state  = ST_RESTORE;
          next_active = succ_ctx;
        end else begin
          next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_LAST)) begin
          next_state  = ST_RESTORE;
          next_active = succ_ctx;
        end else begin
          next_gap = gap_cnt + GAP_W'(1);
        end
      end
      ST_RESTORE: begin
        // active_context already points at the freshly restored context here
        if (context_req[active_context]) next_state = ST_START;
        else if (|context_req)           next_state = ST_SAVE;
        else                             next_state = ST_IDLE;
      end
      ST_START: next_state = ST_RUN;
      default:  next_state = ST_IDLE;
    endcase

    stage_d     = STAGE_IDLE;
    run_start_d = 1'b0;
    ack_d       = '0;
    busy_d      = 1'b0;
    case (next_state)
      ST_SAVE:    begin stage_d = STAGE_WRITE_TO_MEM;  busy_d = 1'b1; end
      ST_GAP:     busy_d = 1'b1;
      ST_RESTORE: begin stage_d = STAGE_READ_FROM_MEM; busy_d = 1'b1; end
      ST_RUN:     stage_d = run_stage;
      ST_START: begin
        run_start_d = 1'b1;
        ack_d       = NUM_CONTEXTS'(1) << next_active;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= ST_IDLE;
      gap_cnt              <= '0;
      active_context       <= '0;
      global_stage         <= STAGE_IDLE;
      local_context_switch <= 1'b1;
      run_start            <= 1'b0;
      context_ack          <= '0;
      busy                 <= 1'b0;
    end else begin
      state                <= next_state;
      gap_cnt              <= next_gap;
      active_context       <= next_active;
      global_stage         <= stage_d;
      // Links compare their registered stage, so the remote flag lags SAVE by one.
      local_context_switch <= (state != ST_SAVE);
      run_start            <= run_start_d;
      context_ack          <= ack_d;
      busy                 <= busy_d;
    end
  end

endmodule
